// File: rtl/mem_asm_serializer_pkg.sv
// Shared types for the assembled-MEM write-back path: the AssemMem record, the
// group trailer layout and the beat-count helper used by the serializer.
package mem_asm_serializer_pkg;

   localparam int RID_W = 16;

   typedef struct packed {
      logic [31:0]      j;
      logic [31:0]      i;
      logic [31:0]      s;
      logic [31:0]      l;
      logic [15:0]      k;
      logic [RID_W-1:0] id;
   } AssemMem;

   localparam int ASM_W = $bits(AssemMem);

   localparam logic [15:0] DEF_TRAILER_MAGIC = 16'hA55E;
   localparam int          DEF_CNT_W         = 16;

   // Trailer layout at the default counter width; magic sits in the low bits.
   typedef struct packed {
      logic [RID_W-1:0]     id;
      logic [DEF_CNT_W-1:0] cnt;
      logic [15:0]          magic;
   } AsmTrailer;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      TRAILER
   } SerState;

   function automatic int ASM_BEATS(input int beatW);
      return (ASM_W + beatW - 1) / beatW;
   endfunction

endpackage

// File: rtl/mem_asm_serializer_beat_mux.sv
// Selects one BEAT_W slice of an AssemMem record; bits past the record on the
// final beat read as zero.
module mem_beat_mux
   import mem_asm_serializer_pkg::*;
#(
   parameter int BEAT_W = 64,
   parameter int NBEATS = 3,
   parameter int IDX_W  = 2
) (
   input  logic [ASM_W-1:0]  rec_i,
   input  logic [IDX_W-1:0]  beatIdx_i,
   output logic [BEAT_W-1:0] beat_o
);

   logic [NBEATS*BEAT_W-1:0] padded;

   always_comb begin
      padded             = '0;
      padded[ASM_W-1:0]  = rec_i;
      beat_o             = padded[beatIdx_i*BEAT_W +: BEAT_W];
   end

endmodule

// File: rtl/mem_asm_serializer.sv
// Serializes AssemMem records into BEAT_W AXI4-Stream beats and closes each read
// group with a trailer beat carrying the record count and read id.
module mem_asm_serializer
   import mem_asm_serializer_pkg::*;
#(
   parameter int          BEAT_W        = 64,
   parameter int          CNT_W         = 16,
   parameter logic [15:0] TRAILER_MAGIC = DEF_TRAILER_MAGIC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ASM_W-1:0]      s_axis_asm_tdata_i,
   input  logic                  s_axis_asm_tvalid_i,
   input  logic                  s_axis_asm_tlast_i,
   output logic                  s_axis_asm_tready_o,
   output logic [BEAT_W-1:0]     m_axis_out_tdata_o,
   output logic                  m_axis_out_tvalid_o,
   output logic                  m_axis_out_tlast_o,
   output logic [BEAT_W/8-1:0]   m_axis_out_tkeep_o,
   output logic [BEAT_W/8-1:0]   m_axis_out_tstrb_o,
   input  logic                  m_axis_out_tready_i,
   output logic                  grp_done_o,
   output logic [CNT_W-1:0]      grp_cnt_o
);

   localparam int                NBEATS   = ASM_BEATS(BEAT_W);
   localparam int                IDX_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBEATS - 1);

   if ((16 + CNT_W + RID_W) > BEAT_W) begin : gTrailerTooWide
      $fatal(1, "mem_asm_serializer: trailer does not fit in one beat");
   end

   SerState           state_q, state_d;
   logic [IDX_W-1:0]  beatIdx_q, beatIdx_d;
   logic [CNT_W-1:0]  recCnt_q, recCnt_d;
   logic [CNT_W-1:0]  grpCnt_q, grpCnt_d;
   logic              grpDone_q, grpDone_d;
   AssemMem           rec_q, rec_d;
   logic              recLast_q, recLast_d;

   logic              acceptRec;
   logic [BEAT_W-1:0] beatData;
   logic [BEAT_W-1:0] trailerData;

   mem_beat_mux #(
      .BEAT_W (BEAT_W),
      .NBEATS (NBEATS),
      .IDX_W  (IDX_W)
   ) uBeatMux (
      .rec_i     (rec_q),
      .beatIdx_i (beatIdx_q),
      .beat_o    (beatData)
   );

   always_comb begin
      trailerData                         = '0;
      trailerData[15:0]                   = TRAILER_MAGIC;
      trailerData[16 +: CNT_W]            = recCnt_q;
      trailerData[16 + CNT_W +: RID_W]    = rec_q.id;
   end

   always_comb begin
      state_d             = state_q;
      beatIdx_d           = beatIdx_q;
      recCnt_d            = recCnt_q;
      grpCnt_d            = grpCnt_q;
      grpDone_d           = 1'b0;
      rec_d               = rec_q;
      recLast_d           = recLast_q;
      acceptRec           = 1'b0;
      s_axis_asm_tready_o = 1'b0;
      m_axis_out_tvalid_o = 1'b0;
      m_axis_out_tlast_o  = 1'b0;
      m_axis_out_tdata_o  = beatData;

      case (state_q)
         IDLE: begin
            s_axis_asm_tready_o = 1'b1;
            acceptRec           = s_axis_asm_tvalid_i;
         end
         SEND: begin
            m_axis_out_tvalid_o = 1'b1;
            if (m_axis_out_tready_i) begin
               if (beatIdx_q != LAST_IDX) begin
                  beatIdx_d = beatIdx_q + 1'b1;
               end else if (recLast_q) begin
                  state_d = TRAILER;
               end else if (s_axis_asm_tvalid_i) begin
                  // Chain straight into the next record so back-to-back records leave no bubble.
                  s_axis_asm_tready_o = 1'b1;
                  acceptRec           = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         TRAILER: begin
            m_axis_out_tvalid_o = 1'b1;
            m_axis_out_tlast_o  = 1'b1;
            m_axis_out_tdata_o  = trailerData;
            if (m_axis_out_tready_i) begin
               grpCnt_d  = recCnt_q;
               grpDone_d = 1'b1;
               recCnt_d  = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (acceptRec) begin
         rec_d     = AssemMem'(s_axis_asm_tdata_i);
         recLast_d = s_axis_asm_tlast_i;
         beatIdx_d = '0;
         recCnt_d  = (recCnt_q == '1) ? recCnt_q : recCnt_q + 1'b1;
         state_d   = SEND;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         beatIdx_q <= '0;
         recCnt_q  <= '0;
         grpCnt_q  <= '0;
         grpDone_q <= 1'b0;
         rec_q     <= '0;
         recLast_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beatIdx_q <= beatIdx_d;
         recCnt_q  <= recCnt_d;
         grpCnt_q  <= grpCnt_d;
         grpDone_q <= grpDone_d;
         rec_q     <= rec_d;
         recLast_q <= recLast_d;
      end
   end

   assign m_axis_out_tkeep_o = '1;
   assign m_axis_out_tstrb_o = '1;
   assign grp_done_o         = grpDone_q;
   assign grp_cnt_o          = grpCnt_q;

endmodule

// File: doc/mem_asm_serializer.md
Name: mem_asm_serializer

Overview:
- Consumer end of the assembled-MEM stream: accepts one AssemMem record per handshake (fields j, i, s, l, k, id) from the MEM assembly stage.
- Slices each record into BEAT_W-bit AXI4-Stream beats for the host write-back DMA.
- Each read group ends on input tlast. After the group's last record, the block appends one trailer beat carrying the group record count and read id; tlast marks the trailer.

Parameters:
- BEAT_W, 64: output beat width in bits.
- CNT_W, 16: width of the per-group record counter in the trailer.
- TRAILER_MAGIC, 16'hA55E: tag in trailer bits [15:0].

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- s_axis_asm, Axi4StreamIf.slave, tdata = ASM_W: AssemMem records; tlast = last record of the read group.
- m_axis_out, Axi4StreamIf.master, tdata = BEAT_W: serialized beats plus trailer.
- grp_done, output, 1: one-cycle pulse on the trailer handshake.
- grp_cnt, output, CNT_W: record count of the most recently completed group; holds until the next trailer.

Behaviour:
- Constant: NBEATS = ceil(ASM_W/BEAT_W), computed in the package.
- Reset (synchronous, high): state IDLE, beat_idx=0, rec_cnt=0, grp_cnt=0, grp_done=0, m tvalid=0, m tlast=0, rec register=0.
- FSM states: IDLE, SEND, TRAILER.
- IDLE:
  - s tready=1, m tvalid=0.
  - On s handshake: latch tdata into rec and tlast into rec_last; beat_idx=0; rec_cnt += 1 (saturating at all-ones); go to SEND.
- SEND:
  - m tvalid=1, m tlast=0.
  - tdata = rec[beat_idx*BEAT_W +: BEAT_W]. Bits above ASM_W on the final beat are zero.
  - On m handshake with beat_idx<NBEATS-1: beat_idx += 1.
  - On m handshake of the final beat:
    - if rec_last: go to TRAILER;
    - else if s tvalid: accept the next record in the same cycle (s tready=1 combinationally for that cycle only), stay in SEND, beat_idx=0;
    - else: go to IDLE.
  - s tready=0 in all other SEND cycles.
- TRAILER:
  - m tvalid=1, m tlast=1.
  - Trailer layout: [15:0]=TRAILER_MAGIC, [16+:CNT_W]=rec_cnt, [16+CNT_W+:RID_W]=rec.id, remaining bits zero.
  - On m handshake: grp_cnt<=rec_cnt, grp_done pulses next cycle, rec_cnt<=0, go to IDLE.
  - s tready=0.
- AXI rules:
  - tdata and tlast are stable while tvalid & ~tready.
  - tvalid never drops without a handshake.
  - tstrb and tkeep are all ones.
- Latency: first beat valid 1 cycle after s handshake. Steady-state throughput: 1 record per NBEATS cycles with m tready held high; the trailer adds 1 cycle per group.
- Count saturation: rec_cnt saturates at 2^CNT_W-1; a saturated trailer reports all ones.
- Elaboration check: 16+CNT_W+RID_W <= BEAT_W; fatal if violated.
- Mid-operation reset: drops the in-flight record and the partial group; no trailer is emitted afterwards.
- Input tkeep/tstrb: ignored.

Decomposition:
- In BwaMemDefines: ASM_BEATS(BEAT_W) as a function; AsmTrailer packed struct {id, cnt, magic}; default TRAILER_MAGIC.
- The AssemMem typedef and RID_W are already in the package; do not redefine them.
- Optional sub-module mem_beat_mux: pure slice/zero-pad selector taking rec and beat_idx.
- FSM and counters stay in the top module.

Test Plan:
- Single record with tlast=1, j=100, i=37, s=55, l=151, k=3, id=9, m tready=1 -> NBEATS beats reproducing the record, then trailer {magic A55E, cnt=1, id=9} with tlast=1; grp_done pulses; grp_cnt=1.
- 5 back-to-back records, last with tlast, m tready=1 -> 5*NBEATS+1 beats with no bubble between records; trailer cnt=5.
- Random m tready (50%) over 200 records in groups of 1..7 -> tdata/tlast stable under backpressure; scoreboard matches every record and trailer count.
- Record accepted while m tready=0 for 20 cycles -> first beat held constant and s tready=0 throughout.
- CNT_W=2, group of 6 records -> trailer cnt=3 (saturated).
- Assert rst while in SEND at beat 1 of a 3-record group -> tvalid=0 the next cycle, no trailer; a following 1-record group yields trailer cnt=1.
